ber_sync_ctrl: RTL

- Sequencing controller for the PRBS9 + BPSK + RC-filter link.
- Generates the baud-rate TX tick and the phase-selected RX sampling tick from one oversampling counter.
- Sweeps a reference-delay select until the sliced RX bit stream aligns with the delayed TX PRBS, then locks and accumulates bit and error counts for BER measurement.
- Sits between the switches/LEDs and the prbs9, filtro_fir, slicer and reference delay-line datapath.

---
 rtl/ber_pkg.sv | 28 ++
 rtl/baud_tick_gen.sv | 61 ++++++
 rtl/ber_sync_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ber_pkg.sv
// Shared constants for the BER sync controller and its datapath neighbours:
// FSM state encoding, default link parameters and a counter-width helper.
package ber_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SEARCH = 2'd2;
  localparam state_t ST_LOCKED = 2'd3;

  localparam int OS_DEF      = 4;
  localparam int DLY_W_DEF   = 9;
  localparam int WIN_DEF     = 512;
  localparam int SETTLE_DEF  = 16;
  localparam int LOSS_TH_DEF = 64;
  localparam int CNT_W_DEF   = 64;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud tick generator: one oversampling counter drives the TX baud tick and
// the phase-selected RX sampling tick. The phase is latched at the baud
// boundary so a change only moves the RX tick from the next baud onward.
module baud_tick_gen
  import ber_pkg::*;
#(
  parameter int OS   = OS_DEF,
  parameter int PH_W = 2
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic            i_tx_en,
  input  logic [PH_W-1:0] i_phase,
  output logic            o_tx_tick,
  output logic            o_rx_tick
);

  localparam int            CW   = cnt_w(OS);
  localparam logic [CW-1:0] LAST = CW'(OS - 1);

  logic [CW-1:0] os_cnt_r;
  logic [CW-1:0] phase_q_r;
  logic [CW-1:0] phase_clamp_s;

  // Clamp an out-of-range phase request to the last sample slot
  always_comb begin
    phase_clamp_s = LAST;
    if (32'(i_phase) >= 32'(OS)) begin
      phase_clamp_s = LAST;
    end else begin
      phase_clamp_s = CW'(i_phase);
    end
  end

  // Oversampling counter: wraps 0..OS-1 while TX is enabled, holds otherwise
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      os_cnt_r <= '0;
    end else if (i_tx_en) begin
      if (os_cnt_r == LAST) begin
        os_cnt_r <= '0;
      end else begin
        os_cnt_r <= os_cnt_r + CW'(1);
      end
    end
  end

  // Phase latch: takes the requested phase on the last slot of each baud
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_q_r <= '0;
    end else if (o_tx_tick) begin
      phase_q_r <= phase_clamp_s;
    end
  end

  // Tick decodes are held low while reset is asserted
  assign o_tx_tick = i_reset && i_tx_en && (os_cnt_r == LAST);
  assign o_rx_tick = i_reset && i_tx_en && (os_cnt_r == phase_q_r);

endmodule

// File: rtl/ber_sync_ctrl.sv
// BER sync controller: sweeps the reference-delay tap until a full window of
// RX samples matches the delayed TX PRBS, then locks and accumulates bit and
// error counts. Losing lock bumps the tap and re-settles without clearing.
module ber_sync_ctrl
  import ber_pkg::*;
#(
  parameter int OS      = OS_DEF,
  parameter int DLY_W   = DLY_W_DEF,
  parameter int WIN     = WIN_DEF,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int LOSS_TH = LOSS_TH_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_tx_en,
  input  logic             i_rx_en,
  input  logic [1:0]       i_phase,
  input  logic             i_rx_bit,
  input  logic             i_ref_bit,
  output logic             o_tx_tick,
  output logic             o_rx_tick,
  output logic [DLY_W-1:0] o_delay_sel,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_ber_zero
);

  localparam int WC_W = cnt_w(WIN);
  localparam int WE_W = $clog2(WIN + 1);
  localparam int SC_W = cnt_w(SETTLE);
  localparam logic [WC_W-1:0] WIN_LAST    = WC_W'(WIN - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [WE_W-1:0] LOSS_LIM    = WE_W'(LOSS_TH);

  state_t           state_r, state_nxt_s;
  logic             rx_en_q_r, locked_r;
  logic [SC_W-1:0]  settle_cnt_r;
  logic [WC_W-1:0]  win_cnt_r;
  logic [WE_W-1:0]  win_err_r, win_err_sum_s;
  logic [DLY_W-1:0] delay_r;
  logic [CNT_W-1:0] bit_cnt_r, err_cnt_r;
  logic             tx_tick_s, rx_tick_s, rise_s, err_s, cnt_en_s;
  logic             settle_end_s, win_end_s, settle_act_s, win_act_s;
  logic             locked_nxt_s, delay_inc_s, acc_clr_s, acc_en_s;

  baud_tick_gen #(.OS(OS), .PH_W(2)) u_ticks (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_tx_en   (i_tx_en),
    .i_phase   (i_phase),
    .o_tx_tick (tx_tick_s),
    .o_rx_tick (rx_tick_s)
  );

  assign rise_s        = i_rx_en && !rx_en_q_r;
  assign err_s         = i_rx_bit ^ i_ref_bit;
  assign cnt_en_s      = rx_tick_s && i_rx_en;
  assign settle_end_s  = cnt_en_s && (settle_cnt_r == SETTLE_LAST);
  assign win_end_s     = cnt_en_s && (win_cnt_r == WIN_LAST);
  assign win_err_sum_s = win_err_r + WE_W'(err_s);
  assign settle_act_s  = i_rx_en && (state_r == ST_SETTLE);
  assign win_act_s     = i_rx_en && ((state_r == ST_SEARCH) || (state_r == ST_LOCKED));

  // State register plus the registered lock flag and enable edge detector
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r   <= ST_IDLE;
      locked_r  <= 1'b0;
      rx_en_q_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      locked_r  <= locked_nxt_s;
      rx_en_q_r <= i_rx_en;
    end
  end

  // Next-state logic; dropping the RX enable always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!i_rx_en) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = rise_s ? ST_SETTLE : ST_IDLE;
        ST_SETTLE: state_nxt_s = settle_end_s ? ST_SEARCH : ST_SETTLE;
        ST_SEARCH: begin
          if (win_end_s) begin
            state_nxt_s = (win_err_sum_s == '0) ? ST_LOCKED : ST_SETTLE;
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (win_end_s && (win_err_sum_s >= LOSS_LIM)) begin
            state_nxt_s = ST_SETTLE;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Control strobes derived from the current/next state pair
  always_comb begin
    delay_inc_s = 1'b0;
    acc_clr_s   = 1'b0;
    acc_en_s    = 1'b0;
    case (state_r)
      ST_IDLE:   acc_clr_s = (state_nxt_s == ST_SETTLE);
      ST_SEARCH: delay_inc_s = (state_nxt_s == ST_SETTLE);
      ST_LOCKED: begin
        delay_inc_s = (state_nxt_s == ST_SETTLE);
        acc_en_s    = cnt_en_s;
      end
      default:   acc_en_s = 1'b0;
    endcase
    locked_nxt_s = (state_nxt_s == ST_LOCKED);
  end

  // Settle counter: counts discarded RX ticks, idle outside SETTLE
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      settle_cnt_r <= '0;
    end else if (!settle_act_s || settle_end_s) begin
      settle_cnt_r <= '0;
    end else if (cnt_en_s) begin
      settle_cnt_r <= settle_cnt_r + SC_W'(1);
    end
  end

  // Window tick and error counters, restarted at every window boundary
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      win_cnt_r <= '0;
      win_err_r <= '0;
    end else if (!win_act_s || win_end_s) begin
      win_cnt_r <= '0;
      win_err_r <= '0;
    end else if (cnt_en_s) begin
      win_cnt_r <= win_cnt_r + WC_W'(1);
      win_err_r <= win_err_sum_s;
    end
  end

  // Reference delay tap: steps (with wrap) after each failed or lost window
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      delay_r <= '0;
    end else if (delay_inc_s) begin
      delay_r <= delay_r + DLY_W'(1);
    end
  end

  // Saturating bit/error accumulators, cleared only when a run starts
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt_r <= '0;
      err_cnt_r <= '0;
    end else if (acc_clr_s) begin
      bit_cnt_r <= '0;
      err_cnt_r <= '0;
    end else if (acc_en_s) begin
      if (bit_cnt_r != '1) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
      if (err_s && (err_cnt_r != '1)) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
    end
  end

  assign o_tx_tick   = tx_tick_s;
  assign o_rx_tick   = rx_tick_s;
  assign o_delay_sel = delay_r;
  assign o_locked    = locked_r;
  assign o_bit_cnt   = bit_cnt_r;
  assign o_err_cnt   = err_cnt_r;
  assign o_ber_zero  = locked_r && (err_cnt_r == '0);

endmodule
